// File: rtl/vga_sync_monitor.sv
// VGA timing self-test: measures hsync/vsync periods and pulse widths against
// expected constants and raises locked once enough consecutive frames are clean.
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    output logic        locked,
    output logic [11:0] h_period,
    output logic [10:0] v_period,
    output logic        h_err,
    output logic        v_err,
    output logic [15:0] frame_count,
    output logic [11:0] pixel_x,
    output logic [10:0] pixel_y
);

    localparam logic [12:0] HTotal     = 13'(H_TOTAL);
    localparam logic [11:0] HSync      = 12'(H_SYNC);
    localparam logic [11:0] VTotal     = 12'(V_TOTAL);
    localparam logic [10:0] VSync      = 11'(V_SYNC);
    localparam logic [3:0]  LockFrames = 4'(LOCK_FRAMES);
    localparam logic [11:0] HMax       = 12'hfff;
    localparam logic [10:0] VMax       = 11'h7ff;

    typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

    logic        hs_q, hs_dly_q, vs_q, vs_dly_q;
    logic        hfall, hrise, vfall, vrise;
    logic [11:0] hcnt_q, hcnt_d, hlow_q, hlow_d;
    logic [10:0] vcnt_q, vcnt_d, vlow_q, vlow_d;
    logic        h_seen_q, v_seen_q;
    logic [11:0] h_period_q;
    logic [10:0] v_period_q;
    logic [12:0] h_len;
    logic [11:0] v_len;
    logic        h_len_bad, h_wid_bad, v_len_bad, v_wid_bad, hsat, bad_now, frame_clean;
    logic        h_err_q, v_err_q, frame_bad_q, frame_bad_d;
    logic [3:0]  good_q, good_d, good_inc;
    logic [15:0] frame_count_q, frame_count_d;
    state_e      state_q, state_d;

    assign hfall = ~hs_q & hs_dly_q;
    assign hrise = hs_q & ~hs_dly_q;
    assign vfall = ~vs_q & vs_dly_q;
    assign vrise = vs_q & ~vs_dly_q;

    always_comb begin
        hcnt_d = hcnt_q;
        if (hfall) begin
            hcnt_d = '0;
        end else if (hcnt_q != HMax) begin
            hcnt_d = hcnt_q + 12'd1;
        end

        hlow_d = hlow_q;
        if (hrise) begin
            hlow_d = '0;
        end else if (!hs_q && hlow_q != HMax) begin
            hlow_d = hlow_q + 12'd1;
        end

        vcnt_d = vcnt_q;
        if (vfall) begin
            vcnt_d = '0;
        end else if (hfall && vcnt_q != VMax) begin
            vcnt_d = vcnt_q + 11'd1;
        end

        // The vfall cycle restarts the width count, including a coincident hfall.
        vlow_d = vlow_q;
        if (vfall) begin
            vlow_d = {10'd0, hfall};
        end else if (vrise) begin
            vlow_d = '0;
        end else if (!vs_q && hfall && vlow_q != VMax) begin
            vlow_d = vlow_q + 11'd1;
        end
    end

    // A line ending together with vfall still belongs to the closing frame.
    assign h_len     = {1'b0, hcnt_q} + 13'd1;
    assign v_len     = {1'b0, vcnt_q} + {11'd0, hfall};
    assign h_len_bad = hfall && h_seen_q && (h_len != HTotal);
    assign h_wid_bad = hrise && h_seen_q && (hlow_q != HSync);
    assign v_len_bad = vfall && v_seen_q && (v_len != VTotal);
    assign v_wid_bad = vrise && v_seen_q && (vlow_q != VSync);
    assign hsat      = (hcnt_d == HMax);
    assign bad_now   = h_len_bad | h_wid_bad | v_len_bad | v_wid_bad | hsat;
    assign good_inc  = good_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        good_d        = good_q;
        frame_count_d = frame_count_q;
        frame_clean   = ~(frame_bad_q | bad_now);
        frame_bad_d   = frame_bad_q | bad_now;
        if (vfall) begin
            frame_bad_d = 1'b0;
        end

        unique case (state_q)
            StSearch: begin
                if (vfall) begin
                    state_d = StCheck;
                    good_d  = '0;
                end
            end
            StCheck: begin
                if (vfall) begin
                    if (frame_clean) begin
                        good_d = good_inc;
                        if (good_inc == LockFrames) begin
                            state_d = StLocked;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            StLocked: begin
                // Lost hsync drops lock on the same edge the counter saturates.
                if (hsat) begin
                    state_d = StSearch;
                end else if (vfall) begin
                    if (frame_clean) begin
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        state_d = StCheck;
                        good_d  = '0;
                    end
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hs_q          <= 1'b1;
            hs_dly_q      <= 1'b1;
            vs_q          <= 1'b1;
            vs_dly_q      <= 1'b1;
            hcnt_q        <= '0;
            hlow_q        <= '0;
            vcnt_q        <= '0;
            vlow_q        <= '0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            h_period_q    <= '0;
            v_period_q    <= '0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            frame_bad_q   <= 1'b0;
            good_q        <= '0;
            frame_count_q <= '0;
            state_q       <= StSearch;
        end else begin
            hs_q          <= hsync;
            hs_dly_q      <= hs_q;
            vs_q          <= vsync;
            vs_dly_q      <= vs_q;
            hcnt_q        <= hcnt_d;
            hlow_q        <= hlow_d;
            vcnt_q        <= vcnt_d;
            vlow_q        <= vlow_d;
            if (hfall) begin
                h_seen_q <= 1'b1;
            end
            if (vfall) begin
                v_seen_q <= 1'b1;
            end
            if (hfall && h_seen_q) begin
                h_period_q <= h_len[11:0];
            end
            if (vfall && v_seen_q) begin
                v_period_q <= v_len[10:0];
            end
            if (h_len_bad || h_wid_bad) begin
                h_err_q <= 1'b1;
            end
            if (v_len_bad || v_wid_bad) begin
                v_err_q <= 1'b1;
            end
            frame_bad_q   <= frame_bad_d;
            good_q        <= good_d;
            frame_count_q <= frame_count_d;
            state_q       <= state_d;
        end
    end

    assign locked      = (state_q == StLocked);
    assign h_period    = h_period_q;
    assign v_period    = v_period_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;
    assign frame_count = frame_count_q;
    assign pixel_x     = hcnt_q;
    assign pixel_y     = vcnt_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a scaled 40x20 raster: stimulus queues expected
// output values stamped with a cycle, a negedge monitor pops and compares them.
module tb_vga_sync_monitor;

    localparam int HT = 40;
    localparam int HS = 6;
    localparam int VT = 20;
    localparam int VS = 2;

    localparam int FLocked = 0;
    localparam int FHPer   = 1;
    localparam int FVPer   = 2;
    localparam int FHErr   = 3;
    localparam int FVErr   = 4;
    localparam int FFCnt   = 5;
    localparam int FPx     = 6;
    localparam int FPy     = 7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        locked;
    logic [11:0] h_period;
    logic [10:0] v_period;
    logic        h_err;
    logic        v_err;
    logic [15:0] frame_count;
    logic [11:0] pixel_x;
    logic [10:0] pixel_y;

    vga_sync_monitor #(
        .H_TOTAL    (HT),
        .H_SYNC     (HS),
        .V_TOTAL    (VT),
        .V_SYNC     (VS),
        .LOCK_FRAMES(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .locked     (locked),
        .h_period   (h_period),
        .v_period   (v_period),
        .h_err      (h_err),
        .v_err      (v_err),
        .frame_count(frame_count),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y)
    );

    typedef struct {
        int    cyc;
        int    field;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   act;
    bit   flush = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int read_field(input int f);
        case (f)
            FLocked: return int'(locked);
            FHPer:   return int'(h_period);
            FVPer:   return int'(v_period);
            FHErr:   return int'(h_err);
            FVErr:   return int'(v_err);
            FFCnt:   return int'(frame_count);
            FPx:     return int'(pixel_x);
            default: return int'(pixel_y);
        endcase
    endfunction

    always @(negedge clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (flush) begin
                checks++;
                failures++;
                $display("FAIL %s: never checked, due cycle %0d, expected %0d",
                         sb[i].name, sb[i].cyc, sb[i].val);
                sb.delete(i);
            end else if (sb[i].cyc <= cyc) begin
                act = read_field(sb[i].field);
                checks++;
                if (sb[i].cyc != cyc || act != sb[i].val) begin
                    failures++;
                    $display("FAIL %s at cycle %0d (due %0d): got %0d, expected %0d",
                             sb[i].name, cyc, sb[i].cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int c, input int f, input int v, input string n);
        exp_t e;
        e.cyc   = c;
        e.field = f;
        e.val   = v;
        e.name  = n;
        sb.push_back(e);
    endtask

    task automatic expect_all_zero(input int c, input string n);
        for (int f = 0; f < 8; f++) begin
            expect_at(c, f, 0, $sformatf("%s_f%0d", n, f));
        end
    endtask

    // Value driven here is sampled at the next edge; outputs follow one edge later.
    task automatic tick(input logic hs, input logic vs);
        hsync = hs;
        vsync = vs;
        @(posedge clock);
        #1;
    endtask

    task automatic gen_frame(input int vs_lines, input int vs_off, input int long_line,
                             input int rst_at);
        int   k;
        int   len;
        logic hs;
        logic vs;
        k = 0;
        for (int l = 0; l < VT; l++) begin
            len = (l == long_line) ? HT + 1 : HT;
            for (int c = 0; c < len; c++) begin
                hs = (c >= HS);
                vs = !(((l > 0) || (c >= vs_off)) &&
                       ((l < vs_lines) || ((l == vs_lines) && (c < vs_off))));
                reset = (k == rst_at);
                tick(hs, vs);
                k++;
            end
        end
    endtask

    int c;

    initial begin
        @(posedge clock);
        #1;
        expect_all_zero(cyc + 1, "reset");
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);

        // Ideal stream, frames 1..8
        for (int f = 1; f <= 8; f++) begin
            c = cyc;
            if (f == 3) begin
                expect_at(c + 1, FLocked, 0, "lock_before");
                expect_at(c + 2, FLocked, 1, "lock_third_vfall");
                expect_at(c + 2, FHPer, HT, "h_period_ideal");
                expect_at(c + 2, FVPer, VT, "v_period_ideal");
                expect_at(c + 2, FHErr, 0, "h_err_ideal");
                expect_at(c + 2, FVErr, 0, "v_err_ideal");
                expect_at(c + 2, FPx, 0, "px_at_vfall");
                expect_at(c + 2, FPy, 0, "py_at_vfall");
                expect_at(c + 7, FPx, 5, "px_count");
                expect_at(c + 42, FPy, 1, "py_count");
            end
            if (f == 8) begin
                expect_at(c + 1, FFCnt, 4, "fcnt_before");
                expect_at(c + 2, FFCnt, 5, "fcnt_five");
            end
            gen_frame(VS, 0, -1, -1);
        end

        // Frame 9 carries one 41-clock line (line 5)
        c = cyc;
        expect_at(c + 2, FLocked, 1, "lock_f9");
        expect_at(c + 2, FFCnt, 6, "fcnt_f9");
        expect_at(c + 242, FHErr, 0, "h_err_before_long");
        expect_at(c + 243, FHPer, HT + 1, "h_period_long");
        expect_at(c + 243, FHErr, 1, "h_err_long");
        expect_at(c + 283, FHPer, HT, "h_period_after_long");
        gen_frame(VS, 0, 5, -1);
        c = cyc;
        expect_at(c + 1, FLocked, 1, "lock_before_bad_vfall");
        expect_at(c + 2, FLocked, 0, "lock_drop_long");
        expect_at(c + 2, FFCnt, 6, "fcnt_no_inc_long");
        expect_at(c + 2, FHErr, 1, "h_err_sticky");
        gen_frame(VS, 0, -1, -1);
        c = cyc;
        expect_at(c + 2, FLocked, 0, "relock_wait_long");
        gen_frame(VS, 0, -1, -1);
        c = cyc;
        expect_at(c + 2, FLocked, 1, "relock_long");
        expect_at(c + 2, FFCnt, 6, "fcnt_relock_long");
        gen_frame(VS, 0, -1, -1);

        // Frame 13 holds vsync low for three lines
        c = cyc;
        expect_at(c + 2, FFCnt, 7, "fcnt_f13");
        expect_at(c + 121, FVErr, 0, "v_err_before_vrise");
        expect_at(c + 122, FVErr, 1, "v_err_wide_vsync");
        gen_frame(3, 0, -1, -1);
        c = cyc;
        expect_at(c + 2, FLocked, 0, "lock_drop_vwide");
        expect_at(c + 2, FVPer, VT, "v_period_vwide");
        gen_frame(VS, 0, -1, -1);
        c = cyc;
        expect_at(c + 2, FLocked, 0, "relock_wait_vwide");
        gen_frame(VS, 0, -1, -1);
        c = cyc;
        expect_at(c + 2, FLocked, 1, "relock_vwide");
        gen_frame(VS, 0, -1, -1);

        // hsync stuck high after one sync pulse
        c = cyc;
        expect_at(c + 2, FPx, 0, "px_stuck_start");
        expect_at(c + 4096, FPx, 4094, "px_before_sat");
        expect_at(c + 4096, FLocked, 1, "lock_before_sat");
        expect_at(c + 4097, FPx, 4095, "px_sat");
        expect_at(c + 4097, FLocked, 0, "lock_drop_sat");
        expect_at(c + 4105, FPx, 4095, "px_held_sat");
        for (int i = 0; i < 4110; i++) tick(i >= HS, 1'b1);
        c = cyc;
        expect_at(c + 2, FLocked, 0, "relock_wait_sat1");
        gen_frame(VS, 0, -1, -1);
        c = cyc;
        expect_at(c + 2, FLocked, 0, "relock_wait_sat2");
        gen_frame(VS, 0, -1, -1);
        c = cyc;
        expect_at(c + 2, FLocked, 1, "relock_sat");
        gen_frame(VS, 0, -1, -1);

        // Reset mid-frame while locked (line 3, clock 20)
        c = cyc;
        expect_at(c + 2, FFCnt, 8, "fcnt_before_reset");
        expect_all_zero(c + 141, "mid_reset");
        expect_at(c + 142, FPx, 1, "px_after_reset");
        expect_at(c + 142, FLocked, 0, "lock_after_reset");
        gen_frame(VS, 0, -1, 140);

        // vsync falls 7 clocks after hsync from here on
        c = cyc;
        expect_at(c + 9, FLocked, 0, "offset_first_vfall");
        gen_frame(VS, 7, -1, -1);
        c = cyc;
        expect_at(c + 9, FLocked, 0, "offset_second_vfall");
        expect_at(c + 9, FVPer, VT, "v_period_offset_first");
        gen_frame(VS, 7, -1, -1);
        c = cyc;
        expect_at(c + 8, FLocked, 0, "offset_lock_before");
        expect_at(c + 9, FLocked, 1, "offset_lock");
        expect_at(c + 9, FVPer, VT, "v_period_offset");
        expect_at(c + 9, FVErr, 0, "v_err_offset");
        expect_at(c + 9, FHErr, 0, "h_err_offset");
        expect_at(c + 9, FPx, 7, "px_offset_vfall");
        expect_at(c + 9, FPy, 0, "py_offset_vfall");
        gen_frame(VS, 7, -1, -1);
        c = cyc;
        expect_at(c + 9, FFCnt, 1, "fcnt_after_reset");
        gen_frame(VS, 7, -1, -1);

        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        flush = 1'b1;
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side checker for the VGA timing produced by the game's display path. It samples `hsync`/`vsync` on the pixel clock and measures line length, frame height and sync pulse widths against 640x480@60 constants. It reconstructs the beam position and raises `locked` once consecutive frames are clean. It sits beside the VGA generator on the `vgaClock` domain as a built-in self-test, feeding LEDs and the scoreboard debug mux.

## Interface
- `H_TOTAL` 800: expected pixel clocks per line.
- `H_SYNC` 96: expected hsync low width, in clocks.
- `V_TOTAL` 525: expected lines per frame.
- `V_SYNC` 2: expected vsync low width, in lines.
- `LOCK_FRAMES` 2: consecutive clean frames required to lock (1..15).

- `clock` in 1: pixel clock (`vgaClock`), the only clock.
- `reset` in 1: synchronous, active-high.
- `hsync` in 1: active-low horizontal sync, synchronous to `clock`.
- `vsync` in 1: active-low vertical sync, synchronous to `clock`.
- `locked` out 1: timing verified.
- `h_period` out 12: last measured line length, in clocks.
- `v_period` out 11: last measured frame height, in lines.
- `h_err` out 1: sticky; any line length or hsync width mismatch since reset.
- `v_err` out 1: sticky; any frame height or vsync width mismatch since reset.
- `frame_count` out 16: frames completed while locked; wraps.
- `pixel_x` out 12: clocks since the last hsync fall (`hcnt`).
- `pixel_y` out 11: lines since the last vsync fall (`vcnt`).

## Operation
- **Input sampling:** both syncs pass through one register stage (`hs_q`, `vs_q`) plus one delay stage.
  - `hfall` = `hs_q`==0 && delayed==1. `hrise`, `vfall` and `vrise` are defined the same way.
- **Horizontal counter:** `hcnt` increments each clock and saturates at 4095.
  - On `hfall`: `hcnt`<=0.
  - If a previous `hfall` was seen (`h_seen`), `h_period`<=`hcnt`+1.
  - A mismatch against `H_TOTAL` sets `h_err` and `frame_bad`.
  - The first `hfall` after reset only sets `h_seen`.
- **Hsync width:** `hlow` counts clocks with `hs_q`==0.
  - On `hrise`, if `h_seen` and `hlow`!=`H_SYNC`, set `h_err` and `frame_bad`.
  - `hlow` clears on `hrise`.
- **Vertical counter:** each cycle `vcnt`<=`vcnt`+`hfall`.
  - On `vfall`: `vcnt`<=0.
  - If `v_seen`, `v_period`<=`vcnt`+`hfall`, and a mismatch against `V_TOTAL` sets `v_err` and `frame_bad`.
  - A simultaneous `hfall`/`vfall` counts that line toward the ending frame.
  - `vcnt` saturates at 2047.
- **Vsync width:** `vlow` counts `hfall` in cycles with `vs_q`==0. This includes the `vfall` cycle and excludes the `vrise` cycle.
  - On `vrise`, if `v_seen` and `vlow`!=`V_SYNC`, set `v_err` and `frame_bad`.
- **Saturation:** `hcnt` reaching 4095 sets `frame_bad`.
- **Lock FSM**, with a 4-bit `good` counter:
  - SEARCH: on `vfall`, go to CHECK with `good`=0 and `frame_bad` cleared.
  - CHECK: on `vfall`, a clean frame increments `good`; reaching `LOCK_FRAMES` moves to LOCKED. A bad frame sets `good`=0 and stays in CHECK. `frame_bad` clears on every `vfall`.
  - LOCKED: `locked`=1.
    - On a clean `vfall`, `frame_count`++.
    - On a bad `vfall`, go to CHECK with `good`=0.
    - When `hcnt` hits 4095, go to SEARCH immediately.
- **Error flags:** `h_err`/`v_err` clear only on reset. Mismatches are flagged in every FSM state.

## Timing
- **Reset:** all outputs are 0, FSM is SEARCH, and `h_seen`/`v_seen`/`frame_bad` and all counters are 0.
- **Measurement latency:** a sync pin change at edge k is sampled at k, its edge is detected during cycle k, and dependent outputs update at edge k+1 (2 clocks pin-to-output).
- **Lock latency:** `locked` asserts at the register update caused by the (`LOCK_FRAMES`+1)-th `vfall` after reset (third with default). It deasserts at the update caused by the offending `vfall`, or on the cycle `hcnt` reaches 4095.
- **Reset mid-operation:** reset in any cycle wins over every edge event in that cycle.

## Test plan
- **Ideal 800x525 stream, hsync low 96, vsync low 2 lines aligned to hsync fall:**
  - `locked`=1 two clocks after the 3rd vsync fall.
  - `h_period`=800, `v_period`=525, `h_err`=`v_err`=0.
  - `frame_count`=5 after 5 further frames.
- **One 801-clock line in locked frame N:**
  - `h_period`=801, then `h_err`=1 (sticky).
  - `locked` falls at frame N's closing vsync fall and returns 2 frames later.
  - `frame_count` does not increment for frame N.
- **vsync held low 3 lines once:** `v_err`=1 at that vrise; lock drops at the next vsync fall; `v_period` stays 525.
- **hsync stuck high while locked:** `pixel_x` saturates at 4095 and `locked`=0 that cycle. Resumed clean timing relocks after 3 vsync falls.
- **vsync fall offset 37 clocks from hsync fall:** `v_period`=525 and `locked`=1, with no `v_err`.
- **Reset asserted mid-frame while locked:** all outputs read 0 the next cycle, and relock takes 3 vsync falls.
